riscv_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It watches the ID stage operands, the ID/EX register outputs and the data-memory handshake. From these it drives the stall/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers: load-use bubble insertion, branch/jump redirect flushing, full-pipeline freeze on a slow data memory, and a timeout fault state.

---
 rtl/riscv_hazard_pkg.sv | 56 +++++
 rtl/riscv_hazard_ctrl_if.sv | 52 +++++
 rtl/riscv_load_use_detect.sv | 22 ++
 rtl/riscv_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_riscv_hazard_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_hazard_pkg.sv
// Shared types and constants for the RISC-V pipeline hazard controller.
// Holds the FSM state encoding, the control-bundle struct and its builders.
package riscv_hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } hz_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic id_ex_stall;
      logic ex_mem_stall;
      logic if_id_flush;
      logic id_ex_flush;
      logic mem_fault;
   } hz_ctrl_t;

   localparam hz_ctrl_t CTRL_NONE = '0;

   // A freeze holds every register and masks all flushes.
   function automatic hz_ctrl_t ctrl_freeze(input logic fault);
      hz_ctrl_t c;
      c             = CTRL_NONE;
      c.pc_stall     = 1'b1;
      c.if_id_stall  = 1'b1;
      c.id_ex_stall  = 1'b1;
      c.ex_mem_stall = 1'b1;
      c.mem_fault    = fault;
      return c;
   endfunction

   // Redirect kills the ID instruction, so it outranks a load-use bubble.
   function automatic hz_ctrl_t ctrl_resolve(input logic redirect, input logic load_use);
      hz_ctrl_t c;
      c = CTRL_NONE;
      if (redirect) begin
         c.if_id_flush = 1'b1;
         c.id_ex_flush = 1'b1;
      end else if (load_use) begin
         c.pc_stall    = 1'b1;
         c.if_id_stall = 1'b1;
         c.id_ex_flush = 1'b1;
      end
      return c;
   endfunction

   function automatic int cnt_width(input int timeout);
      return (timeout <= 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/riscv_hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline observations in, stall/flush controls out.
// RISCV_HAZARD_PERF_EN adds the two performance-counter outputs.
interface riscv_hazard_ctrl_if;

   logic [4:0]  id_rs1_addr;
   logic [4:0]  id_rs2_addr;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic [4:0]  ex_rd_addr;
   logic        ex_mem_read;
   logic        ex_redirect;
   logic        dmem_req;
   logic        dmem_ready;
   logic        fault_ack;

   logic        pc_stall;
   logic        if_id_stall;
   logic        id_ex_stall;
   logic        ex_mem_stall;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        mem_fault;
`ifdef RISCV_HAZARD_PERF_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flush_count;
`endif

   // Controller side.
   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
      input  ex_rd_addr, ex_mem_read, ex_redirect,
      input  dmem_req, dmem_ready, fault_ack,
      output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
      output if_id_flush, id_ex_flush, mem_fault
`ifdef RISCV_HAZARD_PERF_EN
      , output perf_stall_cycles, perf_flush_count
`endif
   );

   // Pipeline side.
   modport master (
      output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
      output ex_rd_addr, ex_mem_read, ex_redirect,
      output dmem_req, dmem_ready, fault_ack,
      input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
      input  if_id_flush, id_ex_flush, mem_fault
`ifdef RISCV_HAZARD_PERF_EN
      , input perf_stall_cycles, perf_flush_count
`endif
   );

endinterface

// File: rtl/riscv_load_use_detect.sv
// Combinational load-use detector: the instruction in ID reads the rd of a load in EX.
module riscv_load_use_detect
   import riscv_hazard_pkg::*;
(
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rd_addr_i,
   input  logic [4:0] id_rs1_addr_i,
   input  logic [4:0] id_rs2_addr_i,
   input  logic       id_uses_rs1_i,
   input  logic       id_uses_rs2_i,
   output logic       load_use_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit    = id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
   assign rs2_hit    = id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);
   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign load_use_o = ex_mem_read_i && (ex_rd_addr_i != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes, dmem freeze, timeout fault.
// Define RISCV_HAZARD_PERF_EN to add the stall-cycle and flush-count performance counters.
module riscv_hazard_ctrl
   import riscv_hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   riscv_hazard_ctrl_if.slave   hz
);

   localparam int             CNT_W     = cnt_width(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
   localparam logic           TIMEOUT_EN = (MEM_TIMEOUT != 0);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   hz_ctrl_t         ctrl_d;
   hz_ctrl_t         ctrl_out;
   logic             load_use;

   riscv_load_use_detect u_lu (
      .ex_mem_read_i (hz.ex_mem_read),
      .ex_rd_addr_i  (hz.ex_rd_addr),
      .id_rs1_addr_i (hz.id_rs1_addr),
      .id_rs2_addr_i (hz.id_rs2_addr),
      .id_uses_rs1_i (hz.id_uses_rs1),
      .id_uses_rs2_i (hz.id_uses_rs2),
      .load_use_o    (load_use)
   );

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl_d  = CTRL_NONE;
      case (state_q)
         RUN: begin
            if (hz.dmem_req && !hz.dmem_ready) begin
               ctrl_d  = ctrl_freeze(1'b0);
               state_d = MEM_WAIT;
               cnt_d   = CNT_W'(1);
            end else begin
               ctrl_d = ctrl_resolve(hz.ex_redirect, load_use);
            end
         end
         MEM_WAIT: begin
            if (!hz.dmem_ready) begin
               ctrl_d = ctrl_freeze(1'b0);
               if (TIMEOUT_EN && (cnt_q == CNT_LIMIT)) begin
                  state_d = FAULT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               // A redirect held in the frozen ID/EX register takes effect on release.
               ctrl_d  = ctrl_resolve(hz.ex_redirect, load_use);
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         FAULT: begin
            ctrl_d = ctrl_freeze(1'b1);
            if (hz.fault_ack) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Controls must read zero the instant reset asserts, not at the next edge.
   assign ctrl_out = rst_n ? ctrl_d : CTRL_NONE;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hz.pc_stall     = ctrl_out.pc_stall;
   assign hz.if_id_stall  = ctrl_out.if_id_stall;
   assign hz.id_ex_stall  = ctrl_out.id_ex_stall;
   assign hz.ex_mem_stall = ctrl_out.ex_mem_stall;
   assign hz.if_id_flush  = ctrl_out.if_id_flush;
   assign hz.id_ex_flush  = ctrl_out.id_ex_flush;
   assign hz.mem_fault    = ctrl_out.mem_fault;

`ifdef RISCV_HAZARD_PERF_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (ctrl_out.pc_stall)    perf_stall_q <= perf_stall_q + 32'd1;
         if (ctrl_out.id_ex_flush) perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign hz.perf_stall_cycles = perf_stall_q;
   assign hz.perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Self-checking bench for riscv_hazard_ctrl (MEM_TIMEOUT = 4); directed scenarios plus a
// randomized run against a behavioural model. Perf checks compile in with RISCV_HAZARD_PERF_EN.
module tb_riscv_hazard_ctrl;

   localparam int TIMEOUT = 4;

   // Output vector order: {pc, if_id, id_ex, ex_mem stalls, if_id flush, id_ex flush, mem_fault}
   localparam logic [6:0] V_ZERO   = 7'b0000000;
   localparam logic [6:0] V_LU     = 7'b1100010;
   localparam logic [6:0] V_REDIR  = 7'b0000110;
   localparam logic [6:0] V_FREEZE = 7'b1111000;
   localparam logic [6:0] V_FAULT  = 7'b1111001;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   riscv_hazard_ctrl_if hz_if ();

   riscv_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state: waiting on memory, faulted, and how many wait cycles so far.
   bit          m_waiting;
   bit          m_fault;
   int          m_waits;
   int unsigned m_stalls;
   int unsigned m_flushes;

   function automatic logic [6:0] obs();
      return {hz_if.pc_stall, hz_if.if_id_stall, hz_if.id_ex_stall, hz_if.ex_mem_stall,
              hz_if.if_id_flush, hz_if.id_ex_flush, hz_if.mem_fault};
   endfunction

   function automatic logic [6:0] model_out();
      bit lu;
      lu = hz_if.ex_mem_read && (hz_if.ex_rd_addr != 5'd0) &&
           ((hz_if.id_uses_rs1 && hz_if.id_rs1_addr == hz_if.ex_rd_addr) ||
            (hz_if.id_uses_rs2 && hz_if.id_rs2_addr == hz_if.ex_rd_addr));
      if (m_fault) return V_FAULT;
      if ((m_waiting || hz_if.dmem_req) && !hz_if.dmem_ready) return V_FREEZE;
      if (hz_if.ex_redirect) return V_REDIR;
      if (lu) return V_LU;
      return V_ZERO;
   endfunction

   task automatic model_reset();
      m_waiting = 0;
      m_fault   = 0;
      m_waits   = 0;
      m_stalls  = 0;
      m_flushes = 0;
   endtask

   task automatic model_step(input logic [6:0] out_now);
      m_stalls  += out_now[6];
      m_flushes += out_now[1];
      if (m_fault) begin
         if (hz_if.fault_ack) m_fault = 0;
      end else if (m_waiting) begin
         if (hz_if.dmem_ready) m_waiting = 0;
         else if (m_waits == TIMEOUT) begin
            m_waiting = 0;
            m_fault   = 1;
         end else m_waits++;
      end else if (hz_if.dmem_req && !hz_if.dmem_ready) begin
         m_waiting = 1;
         m_waits   = 1;
      end
   endtask

   task automatic drive_idle();
      hz_if.id_rs1_addr = 5'd0;
      hz_if.id_rs2_addr = 5'd0;
      hz_if.id_uses_rs1 = 1'b0;
      hz_if.id_uses_rs2 = 1'b0;
      hz_if.ex_rd_addr  = 5'd0;
      hz_if.ex_mem_read = 1'b0;
      hz_if.ex_redirect = 1'b0;
      hz_if.dmem_req    = 1'b0;
      hz_if.dmem_ready  = 1'b0;
      hz_if.fault_ack   = 1'b0;
   endtask

   task automatic drive_lu(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic u1, input logic [4:0] rs2, input logic u2);
      hz_if.ex_mem_read = mr;
      hz_if.ex_rd_addr  = rd;
      hz_if.id_rs1_addr = rs1;
      hz_if.id_uses_rs1 = u1;
      hz_if.id_rs2_addr = rs2;
      hz_if.id_uses_rs2 = u2;
   endtask

   // Leaves time at posedge+1 with reset released and inputs idle.
   task automatic apply_reset();
      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] got;
      drive_idle();
      rst_n = 1'b0;
      // Hazards present during reset must not reach the outputs.
      drive_lu(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      hz_if.dmem_req = 1'b1;
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== V_ZERO) begin
         errors++;
         $display("FAIL reset_hold got=%b exp=%b", got, V_ZERO);
      end
      @(posedge clk);
      #1 drive_idle();
      rst_n = 1'b1;
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== V_ZERO) begin
         errors++;
         $display("FAIL reset_release got=%b exp=%b", got, V_ZERO);
      end
      next_cycle();
   endtask

   typedef struct packed {
      logic       mr;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [6:0] exp;
   } lu_vec_t;

   task automatic test_load_use();
      lu_vec_t    tbl [8];
      logic [6:0] got;
      apply_reset();
      tbl[0] = '{1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, V_LU};   // ld x5; add x6,x5
      tbl[1] = '{1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, V_ZERO}; // bubble now in ID/EX
      tbl[2] = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, V_ZERO}; // load to x0
      tbl[3] = '{1'b1, 5'd5, 5'd5, 1'b0, 5'd9, 1'b1, V_ZERO}; // rs1 not read
      tbl[4] = '{1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, V_LU};   // rs2 dependency
      tbl[5] = '{1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, V_ZERO}; // rs2 not read
      tbl[6] = '{1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, V_ZERO}; // producer is not a load
      tbl[7] = '{1'b1, 5'd31, 5'd31, 1'b1, 5'd31, 1'b1, V_LU};
      for (int i = 0; i < 8; i++) begin
         drive_lu(tbl[i].mr, tbl[i].rd, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2);
         @(negedge clk);
         got = obs();
         checks++;
         if (got !== tbl[i].exp) begin
            errors++;
            $display("FAIL load_use[%0d] got=%b exp=%b", i, got, tbl[i].exp);
         end
         next_cycle();
      end
      drive_idle();
   endtask

   task automatic test_redirect_lu();
      logic [6:0] got;
      apply_reset();
      drive_lu(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      hz_if.ex_redirect = 1'b1;
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== V_REDIR) begin
         errors++;
         $display("FAIL redirect_over_lu got=%b exp=%b", got, V_REDIR);
      end
      next_cycle();
      drive_idle();
   endtask

   task automatic test_mem_wait();
      logic [6:0] got;
      apply_reset();
      // Redirect arrives during the freeze and must wait for the release cycle.
      hz_if.dmem_req    = 1'b1;
      hz_if.ex_redirect = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         got = obs();
         checks++;
         if (got !== V_FREEZE) begin
            errors++;
            $display("FAIL mem_wait[%0d] got=%b exp=%b", i, got, V_FREEZE);
         end
         next_cycle();
      end
      hz_if.dmem_ready = 1'b1;
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== V_REDIR) begin
         errors++;
         $display("FAIL mem_release got=%b exp=%b", got, V_REDIR);
      end
      next_cycle();
      drive_idle();
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== V_ZERO) begin
         errors++;
         $display("FAIL mem_after got=%b exp=%b", got, V_ZERO);
      end
      next_cycle();
   endtask

   task automatic test_timeout_fault();
      logic [6:0] got;
      logic [6:0] exp;
      apply_reset();
      hz_if.dmem_req = 1'b1;
      // One RUN stall cycle plus TIMEOUT wait cycles, then FAULT.
      for (int i = 0; i < TIMEOUT + 3; i++) begin
         if (i == TIMEOUT + 2) hz_if.dmem_ready = 1'b1;
         exp = (i <= TIMEOUT) ? V_FREEZE : V_FAULT;
         @(negedge clk);
         got = obs();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL timeout[%0d] got=%b exp=%b", i, got, exp);
         end
         next_cycle();
      end
      hz_if.fault_ack = 1'b1;
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== V_FAULT) begin
         errors++;
         $display("FAIL fault_ack_cycle got=%b exp=%b", got, V_FAULT);
      end
      next_cycle();
      drive_idle();
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== V_ZERO) begin
         errors++;
         $display("FAIL fault_exit got=%b exp=%b", got, V_ZERO);
      end
      next_cycle();
      // Fault again, then abort with an asynchronous reset in the middle of the cycle.
      hz_if.dmem_req = 1'b1;
      repeat (TIMEOUT + 3) next_cycle();
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== V_FAULT) begin
         errors++;
         $display("FAIL refault got=%b exp=%b", got, V_FAULT);
      end
      #2 rst_n = 1'b0;
      #1 got = obs();
      checks++;
      if (got !== V_ZERO) begin
         errors++;
         $display("FAIL async_reset_fault got=%b exp=%b", got, V_ZERO);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      hz_if.dmem_req = 1'b0;
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== V_ZERO) begin
         errors++;
         $display("FAIL post_reset_run got=%b exp=%b", got, V_ZERO);
      end
      next_cycle();
      drive_idle();
   endtask

   task automatic test_random();
      logic [6:0] got;
      logic [6:0] exp;
      apply_reset();
      for (int i = 0; i < 2000; i++) begin
         hz_if.id_rs1_addr = 5'($urandom_range(0, 3));
         hz_if.id_rs2_addr = 5'($urandom_range(0, 3));
         hz_if.ex_rd_addr  = 5'($urandom_range(0, 3));
         hz_if.id_uses_rs1 = 1'($urandom_range(0, 1));
         hz_if.id_uses_rs2 = 1'($urandom_range(0, 1));
         hz_if.ex_mem_read = 1'($urandom_range(0, 1));
         hz_if.ex_redirect = ($urandom_range(0, 4) == 0);
         hz_if.dmem_req    = ($urandom_range(0, 2) == 0);
         hz_if.dmem_ready  = ($urandom_range(0, 2) == 0);
         hz_if.fault_ack   = ($urandom_range(0, 5) == 0);
         @(negedge clk);
         exp = model_out();
         got = obs();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL random[%0d] got=%b exp=%b", i, got, exp);
         end
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            model_reset();
            @(posedge clk);
            #1 rst_n = 1'b1;
         end else begin
            model_step(exp);
            next_cycle();
         end
      end
`ifdef RISCV_HAZARD_PERF_EN
      checks++;
      if (hz_if.perf_stall_cycles !== m_stalls || hz_if.perf_flush_count !== m_flushes) begin
         errors++;
         $display("FAIL random_perf got=%0d/%0d exp=%0d/%0d", hz_if.perf_stall_cycles,
                  hz_if.perf_flush_count, m_stalls, m_flushes);
      end
`endif
      drive_idle();
   endtask

`ifdef RISCV_HAZARD_PERF_EN
   task automatic test_perf();
      apply_reset();
      checks++;
      if (hz_if.perf_stall_cycles !== 32'd0 || hz_if.perf_flush_count !== 32'd0) begin
         errors++;
         $display("FAIL perf_reset got=%0d/%0d exp=0/0", hz_if.perf_stall_cycles,
                  hz_if.perf_flush_count);
      end
      drive_lu(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      next_cycle();
      drive_idle();
      hz_if.dmem_req = 1'b1;
      repeat (3) next_cycle();
      hz_if.dmem_ready = 1'b1;
      next_cycle();
      drive_idle();
      next_cycle();
      checks++;
      if (hz_if.perf_stall_cycles !== 32'd4 || hz_if.perf_flush_count !== 32'd1) begin
         errors++;
         $display("FAIL perf_count got=%0d/%0d exp=4/1", hz_if.perf_stall_cycles,
                  hz_if.perf_flush_count);
      end
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      drive_idle();
      model_reset();
      test_reset();
      test_load_use();
      test_redirect_lu();
      test_mem_wait();
      test_timeout_fault();
`ifdef RISCV_HAZARD_PERF_EN
      test_perf();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
